// File: rtl/matrix_frame_scheduler.sv
// matrix_frame_scheduler
//   Row-scan controller and frame-boundary arbiter for the 8x8 red/green dot
//   matrix. A clock divider produces one row slot every SCAN_DIV cycles; each
//   slot loads the row select plus the column data of the current owner.
//   Ownership (locked icon, open icon, alarm) only changes on the edge that
//   loads row 7, so every frame is drawn entirely by one source.
//
//   Optional feature macro: ALARM_BLINK_EN
//     When defined, the alarm pattern blinks with a half-period of
//     BLINK_FRAMES frames. When undefined the alarm is steady and no blink
//     logic exists.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   req[2:0]     requests: [0] locked icon, [1] open icon, [2] alarm
//   src_r[23:0]  red column data for row_addr, source i at [8i+7:8i]
//   src_g[23:0]  green column data for row_addr, same packing
//   row_addr     row the sources must present data for
//   grant        one-hot current owner, 000 when idle
//   frame_start  one-cycle pulse after row 0 is loaded
//   row_dian     active-low row select
//   r_col/g_col  active-high red / green columns
module matrix_frame_scheduler #(
  parameter int SCAN_DIV     = 100,
  parameter int HOLD_FRAMES  = 64,
  parameter int BLINK_FRAMES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [23:0] src_r,
  input  logic [23:0] src_g,
  output logic [2:0]  row_addr,
  output logic [2:0]  grant,
  output logic        frame_start,
  output logic [7:0]  row_dian,
  output logic [7:0]  r_col,
  output logic [7:0]  g_col
);

  localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

  if (SCAN_DIV < 1) begin : g_bad_scan_div
    $error("SCAN_DIV must be >= 1");
  end
  if (HOLD_FRAMES < 1) begin : g_bad_hold_frames
    $error("HOLD_FRAMES must be >= 1");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink_frames
    $error("BLINK_FRAMES must be >= 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q;
  logic [2:0]        row_addr_q;
  logic [2:0]        grant_q, grant_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              frame_start_q;
  logic [7:0]        row_dian_q, r_col_q, g_col_q;

  logic              tick;
  logic              boundary;
  logic [2:0]        top_req;
  logic [2:0]        alt_req;
  logic [7:0]        col_r, col_g;

  function automatic logic [2:0] pick(input logic [2:0] r);
    logic [2:0] p;
    p = 3'b000;
    if (r[2])      p = 3'b100;
    else if (r[1]) p = 3'b010;
    else if (r[0]) p = 3'b001;
    return p;
  endfunction

  assign tick     = (div_q == DIV_LAST);
  assign boundary = tick && (row_addr_q == 3'd7);
  assign top_req  = pick(req);
  assign alt_req  = pick(req & ~grant_q);

  // Arbitration, evaluated only on the edge that loads row 7.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    hold_d  = hold_q;
    if (boundary) begin
      case (state_q)
        IDLE: begin
          if (req != 3'b000) begin
            state_d = SHOW;
            grant_d = top_req;
            hold_d  = '0;
          end
        end
        SHOW: begin
          if ((req & grant_q) == 3'b000) begin
            // owner withdrew: hand over at once, hold time irrelevant
            grant_d = alt_req;
            hold_d  = '0;
            if (alt_req == 3'b000) state_d = IDLE;
          end else if (req[2] && !grant_q[2]) begin
            grant_d = 3'b100;
            hold_d  = '0;
          end else if ((top_req != grant_q) && (hold_q >= HOLD_LAST)) begin
            // top_req differs from a still-requesting owner only if higher
            grant_d = top_req;
            hold_d  = '0;
          end else if (hold_q != HOLD_LAST) begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          grant_d = 3'b000;
          hold_d  = '0;
        end
      endcase
    end
  end

`ifdef ALARM_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_off_q, blink_off_d;

  // Phase restarts "on" whenever the alarm newly takes the matrix.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;
    if (boundary) begin
      if (grant_d != 3'b100 || grant_q != 3'b100) begin
        blink_cnt_d = '0;
        blink_off_d = 1'b0;
      end else if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_off_d = !blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end
`endif

  always_comb begin
    col_r = 8'h00;
    col_g = 8'h00;
    case (grant_q)
      3'b001: begin col_r = src_r[7:0];   col_g = src_g[7:0];   end
      3'b010: begin col_r = src_r[15:8];  col_g = src_g[15:8];  end
      3'b100: begin col_r = src_r[23:16]; col_g = src_g[23:16]; end
      default: begin col_r = 8'h00; col_g = 8'h00; end
    endcase
`ifdef ALARM_BLINK_EN
    if (grant_q == 3'b100 && blink_off_q) begin
      col_r = 8'h00;
      col_g = 8'h00;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      div_q         <= '0;
      row_addr_q    <= 3'd0;
      grant_q       <= 3'b000;
      hold_q        <= '0;
      frame_start_q <= 1'b0;
      row_dian_q    <= 8'hFF;
      r_col_q       <= 8'h00;
      g_col_q       <= 8'h00;
`ifdef ALARM_BLINK_EN
      blink_cnt_q   <= '0;
      blink_off_q   <= 1'b0;
`endif
    end else begin
      div_q         <= tick ? '0 : div_q + DIV_W'(1);
      frame_start_q <= tick && (row_addr_q == 3'd0);
      if (tick) begin
        row_dian_q <= ~(8'b1 << row_addr_q);
        r_col_q    <= col_r;
        g_col_q    <= col_g;
        row_addr_q <= row_addr_q + 3'd1;
      end
      state_q <= state_d;
      grant_q <= grant_d;
      hold_q  <= hold_d;
`ifdef ALARM_BLINK_EN
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
`endif
    end
  end

  assign row_addr    = row_addr_q;
  assign grant       = grant_q;
  assign frame_start = frame_start_q;
  assign row_dian    = row_dian_q;
  assign r_col       = r_col_q;
  assign g_col       = g_col_q;

endmodule

// File: tb/tb_matrix_frame_scheduler.sv
module tb_matrix_frame_scheduler;

  localparam int SD    = 4;
  localparam int HF    = 4;
  localparam int BF    = 2;
  localparam int FRAME = 8 * SD;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [23:0] src_r, src_g;
  logic [2:0]  row_addr, grant;
  logic        frame_start;
  logic [7:0]  row_dian, r_col, g_col;

  int total = 0;
  int bad   = 0;

  matrix_frame_scheduler #(
    .SCAN_DIV(SD), .HOLD_FRAMES(HF), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .src_r(src_r), .src_g(src_g),
    .row_addr(row_addr), .grant(grant), .frame_start(frame_start),
    .row_dian(row_dian), .r_col(r_col), .g_col(g_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pattern sources: row-dependent and distinct per source
  function automatic logic [7:0] pat_r(input int i, input logic [2:0] k);
    logic [7:0] v;
    case (i)
      0:       v = 8'h01 << k;
      1:       v = (8'h80 >> k) ^ 8'h0F;
      default: v = {5'b10101, k};
    endcase
    return v;
  endfunction

  function automatic logic [7:0] pat_g(input int i, input logic [2:0] k);
    logic [7:0] v;
    case (i)
      0:       v = 8'h00;
      1:       v = {k, 5'b01010};
      default: v = ~(8'h01 << k);
    endcase
    return v;
  endfunction

  assign src_r = {pat_r(2, row_addr), pat_r(1, row_addr), pat_r(0, row_addr)};
  assign src_g = {pat_g(2, row_addr), pat_g(1, row_addr), pat_g(0, row_addr)};

  typedef struct {
    logic [7:0] rd;
    logic [7:0] rc;
    logic [7:0] gc;
  } row_t;

  row_t sb[$];

  int         m_div   = 0;
  logic [2:0] m_row   = 3'd0;
  logic [2:0] m_grant = 3'b000;
  int         m_hold  = 0;
  logic       m_fs    = 1'b0;
`ifdef ALARM_BLINK_EN
  int         m_bcnt  = 0;
  logic       m_boff  = 1'b0;
`endif

  typedef struct {
    logic [2:0] req;
    int         frames;
    logic [2:0] exp_grant;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] top(input logic [2:0] r);
    if (r[2]) return 3'b100;
    if (r[1]) return 3'b010;
    if (r[0]) return 3'b001;
    return 3'b000;
  endfunction

  task automatic arbitrate();
    logic [2:0] old;
    old = m_grant;
    if (m_grant == 3'b000) begin
      if (req != 3'b000) begin m_grant = top(req); m_hold = 0; end
    end else if ((req & m_grant) == 3'b000) begin
      m_grant = top(req); m_hold = 0;
    end else if (req[2] && m_grant != 3'b100) begin
      m_grant = 3'b100; m_hold = 0;
    end else if (m_grant == 3'b001 && req[1] && m_hold >= HF - 1) begin
      m_grant = 3'b010; m_hold = 0;
    end else if (m_hold < HF - 1) begin
      m_hold++;
    end
`ifdef ALARM_BLINK_EN
    if (m_grant == 3'b100 && old == 3'b100) begin
      if (m_bcnt == BF - 1) begin m_bcnt = 0; m_boff = !m_boff; end
      else m_bcnt++;
    end else begin
      m_bcnt = 0; m_boff = 1'b0;
    end
`endif
  endtask

  task automatic model_step();
    row_t e;
    if (rst) begin
      m_div = 0; m_row = 3'd0; m_grant = 3'b000; m_hold = 0; m_fs = 1'b0;
`ifdef ALARM_BLINK_EN
      m_bcnt = 0; m_boff = 1'b0;
`endif
      e.rd = 8'hFF; e.rc = 8'h00; e.gc = 8'h00;
      sb.push_back(e);
    end else begin
      m_fs = 1'b0;
      if (m_div == SD - 1) begin
        m_div = 0;
        e.rd = ~(8'h01 << m_row);
        e.rc = 8'h00;
        e.gc = 8'h00;
        case (m_grant)
          3'b001: begin e.rc = pat_r(0, m_row); e.gc = pat_g(0, m_row); end
          3'b010: begin e.rc = pat_r(1, m_row); e.gc = pat_g(1, m_row); end
          3'b100: begin e.rc = pat_r(2, m_row); e.gc = pat_g(2, m_row); end
          default: ;
        endcase
`ifdef ALARM_BLINK_EN
        if (m_grant == 3'b100 && m_boff) begin e.rc = 8'h00; e.gc = 8'h00; end
`endif
        sb.push_back(e);
        if (m_row == 3'd0) m_fs = 1'b1;
        if (m_row == 3'd7) arbitrate();
        m_row = m_row + 3'd1;
      end else begin
        m_div++;
      end
    end
  endtask

  task automatic check_cycle();
    row_t e;
    chk("grant", {29'd0, grant}, {29'd0, m_grant});
    chk("row_addr", {29'd0, row_addr}, {29'd0, m_row});
    chk("frame_start", {31'd0, frame_start}, {31'd0, m_fs});
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("row_dian", {24'd0, row_dian}, {24'd0, e.rd});
      chk("r_col", {24'd0, r_col}, {24'd0, e.rc});
      chk("g_col", {24'd0, g_col}, {24'd0, e.gc});
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{3'b000, 1, 3'b000};
    tbl[1]  = '{3'b001, 1, 3'b001};
    tbl[2]  = '{3'b011, 3, 3'b001};
    tbl[3]  = '{3'b011, 1, 3'b010};
    tbl[4]  = '{3'b011, 1, 3'b010};
    tbl[5]  = '{3'b111, 1, 3'b100};
    tbl[6]  = '{3'b011, 1, 3'b010};
    tbl[7]  = '{3'b001, 1, 3'b001};
    tbl[8]  = '{3'b010, 1, 3'b010};
    tbl[9]  = '{3'b011, 1, 3'b010};
    tbl[10] = '{3'b100, 1, 3'b100};
    tbl[11] = '{3'b000, 1, 3'b000};
    tbl[12] = '{3'b110, 1, 3'b100};
    tbl[13] = '{3'b010, 1, 3'b010};
    tbl[14] = '{3'b011, 5, 3'b010};
    tbl[15] = '{3'b001, 1, 3'b001};
    tbl[16] = '{3'b100, 6, 3'b100};
    tbl[17] = '{3'b000, 1, 3'b000};

    rst = 1'b1;
    req = 3'b000;
    repeat (3) cyc();
    chk("rst_row_dian", {24'd0, row_dian}, 32'hFF);
    chk("rst_grant", {29'd0, grant}, 32'h0);
    rst = 1'b0;

    // first row slot lands on the 4th edge after release
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("pre_tick_row_dian", {24'd0, row_dian}, 32'hFF);
    end
    cyc();
    chk("first_row_dian", {24'd0, row_dian}, 32'hFE);
    chk("first_frame_start", {31'd0, frame_start}, 32'h1);
    repeat (FRAME - 4) cyc();

    for (int v = 0; v < NV; v++) begin
      req = tbl[v].req;
      repeat (tbl[v].frames * FRAME) cyc();
      chk($sformatf("tbl%0d_grant", v), {29'd0, grant}, {29'd0, tbl[v].exp_grant});
    end

    // reset in the middle of a frame
    req = 3'b001;
    repeat (FRAME) cyc();
    chk("pre_mid_rst_grant", {29'd0, grant}, 32'h1);
    repeat (13) cyc();
    rst = 1'b1;
    cyc();
    chk("mid_rst_row_dian", {24'd0, row_dian}, 32'hFF);
    chk("mid_rst_r_col", {24'd0, r_col}, 32'h0);
    chk("mid_rst_grant", {29'd0, grant}, 32'h0);
    chk("mid_rst_row_addr", {29'd0, row_addr}, 32'h0);
    repeat (2) cyc();
    rst = 1'b0;
    req = 3'b010;
    repeat (FRAME) cyc();
    chk("after_rst_grant", {29'd0, grant}, 32'h2);

    // alarm raised mid-frame takes over only at the boundary
    repeat (10) cyc();
    req = 3'b110;
    repeat (FRAME - 11) cyc();
    chk("alarm_midframe_grant", {29'd0, grant}, 32'h2);
    cyc();
    chk("alarm_boundary_grant", {29'd0, grant}, 32'h4);
    repeat (FRAME) cyc();

    // alarm withdrawn: idle, rows keep scanning with dark columns
    req = 3'b000;
    repeat (FRAME) cyc();
    chk("idle_grant", {29'd0, grant}, 32'h0);
    repeat (FRAME) cyc();
    chk("idle_r_col", {24'd0, r_col}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_frame_scheduler.md
Name: matrix_frame_scheduler

Overview:
Scan controller and arbiter for the 8x8 red/green dot matrix on the password-lock board. Generates row-scan timing from clk. Arbitrates matrix ownership among three pattern sources (locked icon, open icon, alarm), switching owners only on frame boundaries. Sources decode the row_addr output combinationally, and this block registers the selected row onto row_dian, r_col and g_col.

Parameters:
SCAN_DIV, 100, clk cycles per row slot (legal range >= 1)
HOLD_FRAMES, 64, minimum whole frames a granted source keeps the matrix before a non-alarm preemption (legal range >= 1)
BLINK_FRAMES, 32, frames per blink half-period (used only with the optional feature; legal range >= 1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req  in  3  request: [0] locked icon, [1] open icon, [2] alarm
src_r  in  24  red column data for row_addr; source i occupies [8i+7:8i]
src_g  in  24  green column data for row_addr; same packing as src_r
row_addr  out  3  row index the sources must present data for
grant  out  3  one-hot current owner; 000 when idle
frame_start  out  1  one-cycle pulse when row 0 is loaded
row_dian  out  8  active-low row select
r_col  out  8  red columns, active-high
g_col  out  8  green columns, active-high

Behaviour:
- Reset values: row_dian=8'hFF, r_col=0, g_col=0, grant=0, frame_start=0, row_addr=0. Divider, hold counter and blink counter are 0; state is IDLE. Reset takes effect at the clock edge whenever it is asserted, including mid-frame, and discards any pending switch.
- Divider: counts 0..SCAN_DIV-1. tick is asserted in the cycle where count==SCAN_DIV-1, and the count wraps to 0 on the following edge. With SCAN_DIV=1, tick is high every cycle.
- Row load on tick:
  - row_dian <= ~(8'b1 << row_addr).
  - r_col/g_col <= the granted source's slice. They are 0 when grant=0.
  - row_addr increments modulo 8. Exactly 8 rows per frame, with no dead slot.
- Frame boundary: the tick that loads row 7.
  - All arbitration is evaluated there.
  - The new grant is registered on that same edge, so the next frame's row 0 is fetched with the new owner (row_addr=0 then).
- frame_start: high for the one cycle following the edge that loads row 0.
- FSM states:
  - IDLE: grant=0. At a boundary with any req set, go to SHOW, grant the highest set req (priority 2>1>0) and clear the hold counter.
  - SHOW, evaluated at each boundary:
    - If req[granted] is clear: re-arbitrate among the remaining reqs. If none remain, go to IDLE. The hold time is ignored.
    - Else if req[2] is set and the owner is not 2: grant 2 immediately, whatever the hold count.
    - Else if a higher-priority req is set and hold count >= HOLD_FRAMES-1: grant it.
    - Otherwise keep the current owner.
    - The hold counter increments per frame, saturates, and clears on every grant change.
- Simultaneous new requests: the highest priority wins. Lower-priority requests are not queued; they are just re-evaluated at later boundaries.
- req may change at any cycle; only its value at the boundary tick matters.

Optional Feature:
ALARM_BLINK_EN
- Defined, alarm owner: while grant=100, a frame counter toggles a blink phase every BLINK_FRAMES frames. In the off phase, r_col/g_col load 0 while row_dian still scans. The phase resets to on, with the counter at 0, whenever grant changes to 100.
- Defined, other owners: no blinking.
- Undefined: the alarm pattern is steady and no blink logic is present.

Test Plan:
- Reset, SCAN_DIV=4: hold rst 3 cycles, then release -> outputs FF/00/00/000 until the first tick. First tick at cycle 3 after release loads row_dian=FE. Assert rst mid-frame -> outputs return to reset values on the next edge.
- req=001, src_r[7:0]=row-dependent pattern -> row_dian sequence FE,FD,FB,F7,EF,DF,BF,7F,FE. frame_start repeats every 32 cycles. From the frame after the grant, r_col matches the source per row, g_col=0, and grant=001.
- HOLD_FRAMES=4, owner 001, req becomes 011 in frame 1 -> grant stays 001 through the end of hold, becomes 010 at the 4th boundary, and the first row of the new owner is row 0.
- Owner 010 granted 1 frame ago, req[2] asserted mid-frame -> grant=100 at the next boundary, not mid-frame. r_col/g_col switch to src slice 2 at row 0.
- Owner 100, req drops to 000 -> IDLE at the next boundary. r_col/g_col=0 while row_dian keeps scanning.
- ALARM_BLINK_EN, BLINK_FRAMES=2, alarm granted -> columns on for frames 0-1, 0 for frames 2-3, on for 4-5. Without the macro -> on for all frames.
